rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/rr_arbiter_8_pkg.sv | 10 +
 rtl/rr_arbiter_8_prio_enc.sv | 27 ++
 rtl/rr_arbiter_8.sv | 118 +++++++++++
 tb/tb_rr_arbiter_8.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: FSM encoding and sizes.
package rr_arbiter_8_pkg;
  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arbiter_8_prio_enc.sv
// Rotating-priority search: first set req bit at or above ptr, wrapping 7->0.
module rr_prio_enc8
  import rr_arbiter_8_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with registered one-hot grant.
// Optional hold-timeout preemption is compiled in with `define RR_ARB_TIMEOUT_EN.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_id,
  output logic               gnt_valid,
  output logic               preempt
);

  generate
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("rr_arbiter_8: MAX_HOLD must be within 2..255");
    end
  endgenerate

  state_t             state, state_nx;
  logic [NUM_REQ-1:0] gnt_nx;
  logic [IDX_W-1:0]   gnt_id_nx;
  logic               gnt_valid_nx;
  logic               preempt_nx;
  logic [IDX_W-1:0]   ptr, ptr_nx;
  logic               found;
  logic [IDX_W-1:0]   idx;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt, hold_cnt_nx;
`endif

  rr_prio_enc8 u_prio (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .idx   (idx)
  );

  always_comb begin
    state_nx     = state;
    gnt_nx       = gnt;
    gnt_id_nx    = gnt_id;
    gnt_valid_nx = gnt_valid;
    ptr_nx       = ptr;
    preempt_nx   = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    hold_cnt_nx  = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (enable && found) begin
          state_nx     = GRANT;
          gnt_nx       = NUM_REQ'(1) << idx;
          gnt_id_nx    = idx;
          gnt_valid_nx = 1'b1;
          ptr_nx       = idx + IDX_W'(1);
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt_nx  = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[gnt_id]) begin
          state_nx     = IDLE;
          gnt_nx       = '0;
          gnt_valid_nx = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        // Revoke only if someone else is waiting; otherwise hold the count at the limit.
        end else if (hold_cnt == HOLD_LIM && (req & ~gnt) != '0) begin
          state_nx     = IDLE;
          gnt_nx       = '0;
          gnt_valid_nx = 1'b0;
          preempt_nx   = 1'b1;
        end else if (hold_cnt != HOLD_LIM) begin
          hold_cnt_nx  = hold_cnt + 8'd1;
`endif
        end
      end
      default: begin
        state_nx     = IDLE;
        gnt_nx       = '0;
        gnt_valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
      ptr       <= '0;
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      gnt_id    <= gnt_id_nx;
      gnt_valid <= gnt_valid_nx;
      preempt   <= preempt_nx;
      ptr       <= ptr_nx;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else        hold_cnt <= hold_cnt_nx;
  end
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Table-driven and sequence bench for rr_arbiter_8 with a queue-based scoreboard.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       vld;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       vld;
    logic       pre;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[25];

  function automatic vec_t mk(input logic en, input logic [7:0] r, input logic [7:0] g,
                              input logic [2:0] id, input logic v);
    vec_t t;
    t.en = en; t.req = r; t.gnt = g; t.id = id; t.vld = v;
    return t;
  endfunction

  task automatic compare(input string name, input logic [7:0] g, input logic [2:0] id,
                         input logic v, input logic p);
    n_cmp++;
    if (gnt !== g || gnt_valid !== v || preempt !== p || (v && gnt_id !== id)) begin
      n_bad++;
      $display("FAIL %s: got gnt=%h id=%0d vld=%b pre=%b, want gnt=%h id=%0d vld=%b pre=%b",
               name, gnt, gnt_id, gnt_valid, preempt, g, id, v, p);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic cyc(input string name, input logic en, input logic [7:0] r,
                     input logic [7:0] g, input logic [2:0] id, input logic v, input logic p);
    exp_t e;
    enable = en;
    req    = r;
    e.name = name; e.gnt = g; e.id = id; e.vld = v; e.pre = p;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare(e.name, e.gnt, e.id, e.vld, e.pre);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    req    = 8'h00;
    #1;
    compare("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [2:0] o;

    tbl[0]  = mk(1'b1, 8'h01, 8'h01, 3'd0, 1'b1);
    tbl[1]  = mk(1'b1, 8'h00, 8'h00, 3'd0, 1'b0);
    tbl[2]  = mk(1'b0, 8'h10, 8'h00, 3'd0, 1'b0);
    tbl[3]  = mk(1'b0, 8'h10, 8'h00, 3'd0, 1'b0);
    tbl[4]  = mk(1'b1, 8'h10, 8'h10, 3'd4, 1'b1);
    tbl[5]  = mk(1'b0, 8'h10, 8'h10, 3'd4, 1'b1);
    tbl[6]  = mk(1'b0, 8'h1F, 8'h10, 3'd4, 1'b1);
    tbl[7]  = mk(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    tbl[8]  = mk(1'b1, 8'h41, 8'h40, 3'd6, 1'b1);
    tbl[9]  = mk(1'b1, 8'h41, 8'h40, 3'd6, 1'b1);
    tbl[10] = mk(1'b1, 8'h01, 8'h00, 3'd0, 1'b0);
    tbl[11] = mk(1'b1, 8'h01, 8'h01, 3'd0, 1'b1);
    tbl[12] = mk(1'b1, 8'h00, 8'h00, 3'd0, 1'b0);
    tbl[13] = mk(1'b1, 8'h80, 8'h80, 3'd7, 1'b1);
    tbl[14] = mk(1'b1, 8'h81, 8'h80, 3'd7, 1'b1);
    tbl[15] = mk(1'b1, 8'h01, 8'h00, 3'd0, 1'b0);
    tbl[16] = mk(1'b1, 8'h01, 8'h01, 3'd0, 1'b1);
    tbl[17] = mk(1'b1, 8'h05, 8'h01, 3'd0, 1'b1);
    tbl[18] = mk(1'b1, 8'h01, 8'h01, 3'd0, 1'b1);
    tbl[19] = mk(1'b1, 8'h00, 8'h00, 3'd0, 1'b0);
    tbl[20] = mk(1'b1, 8'h00, 8'h00, 3'd0, 1'b0);
    tbl[21] = mk(1'b1, 8'h81, 8'h80, 3'd7, 1'b1);
    tbl[22] = mk(1'b1, 8'h01, 8'h00, 3'd0, 1'b0);
    tbl[23] = mk(1'b1, 8'h01, 8'h01, 3'd0, 1'b1);
    tbl[24] = mk(1'b1, 8'h00, 8'h00, 3'd0, 1'b0);

    do_reset();
    for (int i = 0; i < 25; i++)
      cyc($sformatf("vec%0d", i), tbl[i].en, tbl[i].req, tbl[i].gnt, tbl[i].id, tbl[i].vld, 1'b0);

    // Full rotation with every requester active; each owner releases after 3 cycles.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      o = 3'(k % 8);
      b = 8'h01 << o;
      for (int c = 0; c < 3; c++)
        cyc($sformatf("rot_own%0d_c%0d", k, c), 1'b1, 8'hFF, b, o, 1'b1, 1'b0);
      cyc($sformatf("rot_gap%0d", k), 1'b1, 8'hFF & ~b, 8'h00, 3'd0, 1'b0, 1'b0);
    end

    // Reset asserted mid-grant, held across an edge, then released.
    do_reset();
    cyc("pre_rst_g3", 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    compare("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    req    = 8'h0C;
    enable = 1'b1;
    @(posedge clk);
    #1;
    compare("rst_held_edge", 8'h00, 3'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    cyc("post_rst_g2", 1'b1, 8'h0C, 8'h04, 3'd2, 1'b1, 1'b0);

    do_reset();
`ifdef RR_ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++)
      cyc($sformatf("to_hold%0d", c), 1'b1, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0);
    cyc("to_preempt", 1'b1, 8'h03, 8'h00, 3'd0, 1'b0, 1'b1);
    cyc("to_next", 1'b1, 8'h03, 8'h02, 3'd1, 1'b1, 1'b0);
    cyc("to_release", 1'b1, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);
    cyc("to_solo_grant", 1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++)
      cyc($sformatf("to_sat%0d", c), 1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
`else
    for (int c = 0; c < 10; c++)
      cyc($sformatf("no_to_hold%0d", c), 1'b1, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
